// File: rtl/wb_ram_slave.sv
// Wishbone B3 RAM slave: single-port word RAM with byte-lane writes and
// registered-feedback incrementing bursts (linear, wrap-4, wrap-8, wrap-16).
module wb_ram_slave #(
    parameter int unsigned dw    = 32,
    parameter int unsigned aw    = 32,
    parameter int unsigned depth = 1024
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);

    localparam int unsigned      WordW  = aw - 2;
    localparam int unsigned      IdxW   = $clog2(depth);
    localparam logic [WordW-1:0] DepthW = WordW'(depth);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e           state_q;
    logic [WordW-1:0] cur_adr_q;
    logic [dw-1:0]    dat_q;
    logic             ack_q;
    logic             err_q;

    logic [dw-1:0]    mem [depth];

    logic             req;
    logic [WordW-1:0] word_idx;
    logic [WordW-1:0] nxt_adr;
    logic             word_ok;
    logic             nxt_ok;
    logic             unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    assign word_idx   = wb_adr_i[aw-1:2];
    assign unused_adr = ^wb_adr_i[1:0];
    assign word_ok    = word_idx < DepthW;
    assign nxt_ok     = nxt_adr < DepthW;

    // Wrapping bursts only advance the low field; upper bits stay put.
    always_comb begin
        nxt_adr = cur_adr_q;
        case (wb_bte_i)
            2'b00:   nxt_adr      = cur_adr_q + WordW'(1);
            2'b01:   nxt_adr[1:0] = cur_adr_q[1:0] + 2'd1;
            2'b10:   nxt_adr[2:0] = cur_adr_q[2:0] + 3'd1;
            default: nxt_adr[3:0] = cur_adr_q[3:0] + 4'd1;
        endcase
    end

    // A beat is written on the edge that completes its ack handshake.
    always_ff @(posedge wb_clk_i) begin
        if (ack_q && req && wb_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem[cur_adr_q[IdxW-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= StIdle;
            cur_adr_q <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req && !ack_q) begin
                        if (word_ok) begin
                            cur_adr_q <= word_idx;
                            dat_q     <= mem[word_idx[IdxW-1:0]];
                            ack_q     <= 1'b1;
                            if (wb_cti_i == 3'b010) begin
                                state_q <= StBurst;
                            end
                        end else if (!err_q) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StBurst: begin
                    if (!wb_cyc_i) begin
                        state_q <= StIdle;
                    end else if (wb_stb_i) begin
                        if (!ack_q) begin
                            // Master resumes after a wait state: re-present the held beat.
                            dat_q <= mem[cur_adr_q[IdxW-1:0]];
                            ack_q <= 1'b1;
                        end else if (wb_cti_i == 3'b111) begin
                            state_q <= StIdle;
                        end else if (nxt_ok) begin
                            cur_adr_q <= nxt_adr;
                            dat_q     <= mem[nxt_adr[IdxW-1:0]];
                            ack_q     <= 1'b1;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Randomized bench for wb_ram_slave: a word-array model of the RAM plus an
// arithmetic model of burst address sequences predicts every beat.
module tb_wb_ram_slave;

    localparam int Depth = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    logic [31:0] model [Depth];
    bit          known [Depth];
    logic [31:0] wdata [64];
    logic [31:0] rdata [64];
    int          n_checks;
    int          n_errors;

    always #5 clk = ~clk;

    wb_ram_slave #(
        .dw   (32),
        .aw   (32),
        .depth(Depth)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Word index of beat k of a burst starting at word 'start'.
    function automatic int exp_word(input int start, input int k, input logic [1:0] bte);
        int len;
        if (bte == 2'b00) return start + k;
        len = (bte == 2'b01) ? 4 : (bte == 2'b10) ? 8 : 16;
        return start - (start % len) + ((start % len) + k) % len;
    endfunction

    task automatic write_model(input int w, input logic [31:0] d, input logic [3:0] sel);
        if (w >= 0 && w < Depth) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) model[w][8*b +: 8] = d[8*b +: 8];
            end
            if (sel == 4'hF) known[w] = 1'b1;
        end
    endtask

    task automatic idle_bus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_cti_i = 3'b000;
        wb_bte_i = 2'b00;
        wb_sel_i = 4'h0;
        wb_adr_i = 32'h0;
        wb_dat_i = 32'h0;
    endtask

    // Only the first beat carries a real address; later ones carry noise.
    task automatic drive_beat(input int beat, input int n, input int start,
                              input logic [1:0] bte, input logic we, input logic [3:0] sel);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_bte_i = bte;
        wb_dat_i = wdata[beat];
        wb_adr_i = (beat == 0) ? 32'(start * 4) : $urandom;
        if (n == 1) wb_cti_i = 3'b000;
        else wb_cti_i = (beat == n - 1) ? 3'b111 : 3'b010;
    endtask

    // n == 1 gives a classic cycle. stall_at >= 1 drops stb for two cycles
    // once that many beats have completed.
    task automatic do_burst(input int start, input int n, input logic [1:0] bte,
                            input logic we, input logic [3:0] sel, input int stall_at);
        int beat       = 0;
        int acks       = 0;
        int stall_left = 0;
        int pend_w     = -1;
        int exp_acks   = 0;
        int w;
        bit exp_err    = 1'b0;
        bit got_err    = 1'b0;
        bit done       = 1'b0;
        bit pending    = 1'b0;
        bit seen       = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (exp_word(start, k, bte) >= Depth) begin
                exp_err = 1'b1;
                break;
            end
            exp_acks++;
        end
        drive_beat(0, n, start, bte, we, sel);
        for (int c = 1; c <= 4 * n + 16 && !done; c++) begin
            @(posedge clk);
            #1;
            if (pending) begin
                pending = 1'b0;
                if (we) write_model(pend_w, wdata[beat], sel);
                beat++;
                if (beat == n) begin
                    done = 1'b1;
                    idle_bus();
                end else begin
                    drive_beat(beat, n, start, bte, we, sel);
                    if (beat == stall_at) begin
                        wb_stb_i   = 1'b0;
                        stall_left = 3;
                    end
                end
            end
            if (done) begin
                check("end_ack", 32'(wb_ack_o), 0);
            end else if (wb_err_o) begin
                if (!seen) check("err_latency", c, 1);
                seen    = 1'b1;
                got_err = 1'b1;
                done    = 1'b1;
                check("err_ack_excl", 32'(wb_ack_o), 0);
                idle_bus();
            end else if (stall_left > 0) begin
                if (stall_left < 3) check("stall_ack", 32'(wb_ack_o), 0);
                stall_left--;
                if (stall_left == 0) wb_stb_i = 1'b1;
            end else if (wb_ack_o) begin
                if (!seen) check("ack_latency", c, 1);
                seen = 1'b1;
                w    = exp_word(start, beat, bte);
                if (w < Depth && known[w]) check("rdata", wb_dat_o, model[w]);
                rdata[beat] = wb_dat_o;
                pend_w      = w;
                pending     = 1'b1;
                acks++;
            end
        end
        if (!done) begin
            check("timeout", 0, 1);
            idle_bus();
        end
        check("ack_count", acks, exp_acks);
        check("err_flag", 32'(got_err), 32'(exp_err));
        @(posedge clk);
        #1;
        check("idle_ack", 32'(wb_ack_o), 0);
        check("idle_err", 32'(wb_err_o), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(wb_ack_o), 0);
        check("rst_err", 32'(wb_err_o), 0);
        check("rst_rty", 32'(wb_rty_o), 0);
        check("rst_dat", wb_dat_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill the whole RAM so later reads have known contents.
        for (int k = 0; k < Depth; k++) wdata[k] = $urandom;
        do_burst(0, Depth, 2'b00, 1'b1, 4'hF, -1);

        wdata[0] = 32'hDEADBEEF;
        do_burst(4, 1, 2'b00, 1'b1, 4'hF, -1);
        do_burst(4, 1, 2'b00, 1'b0, 4'hF, -1);
        check("rd_0x10", rdata[0], 32'hDEADBEEF);

        wdata[0] = 32'h11223344;
        do_burst(8, 1, 2'b00, 1'b1, 4'hF, -1);
        wdata[0] = 32'hAABBCCDD;
        do_burst(8, 1, 2'b00, 1'b1, 4'b0101, -1);
        do_burst(8, 1, 2'b00, 1'b0, 4'hF, -1);
        check("byte_lanes", rdata[0], 32'h11BB33DD);

        do_burst(6, 4, 2'b01, 1'b0, 4'hF, -1);
        check("wrap4_beat2", rdata[2], model[4]);

        do_burst(Depth - 2, 3, 2'b00, 1'b0, 4'hF, -1);

        for (int k = 0; k < 4; k++) wdata[k] = $urandom;
        do_burst(0, 4, 2'b00, 1'b1, 4'hF, 2);
        do_burst(0, 4, 2'b00, 1'b0, 4'hF, -1);

        do_burst(Depth, 1, 2'b00, 1'b1, 4'hF, -1);

        // Reset while the third beat of a write burst is being acked.
        for (int k = 0; k < 4; k++) wdata[k] = $urandom;
        drive_beat(0, 4, 40, 2'b00, 1'b1, 4'hF);
        @(posedge clk);
        #1;
        check("rst_burst_ack0", 32'(wb_ack_o), 1);
        @(posedge clk);
        #1;
        write_model(40, wdata[0], 4'hF);
        drive_beat(1, 4, 40, 2'b00, 1'b1, 4'hF);
        check("rst_burst_ack1", 32'(wb_ack_o), 1);
        @(posedge clk);
        #1;
        write_model(41, wdata[1], 4'hF);
        drive_beat(2, 4, 40, 2'b00, 1'b1, 4'hF);
        check("rst_burst_ack2", 32'(wb_ack_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ack", 32'(wb_ack_o), 0);
        check("async_rst_err", 32'(wb_err_o), 0);
        check("async_rst_dat", wb_dat_o, 0);
        @(posedge clk);
        #1;
        idle_bus();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_burst(42, 1, 2'b00, 1'b0, 4'hF, -1);
        do_burst(40, 2, 2'b00, 1'b0, 4'hF, -1);

        for (int i = 0; i < 30; i++) begin
            int         start;
            int         n;
            int         stall;
            logic [1:0] bte;
            logic       we;
            logic [3:0] sel;
            we  = 1'($urandom);
            sel = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                n     = 1;
                bte   = 2'b00;
                start = $urandom_range(0, Depth + 3);
                stall = -1;
            end else begin
                n     = $urandom_range(2, 12);
                bte   = 2'($urandom);
                start = $urandom_range(0, Depth - 1);
                if (bte == 2'b00 && $urandom_range(0, 2) == 0) begin
                    start = Depth - $urandom_range(1, 4);
                end
                stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
            end
            for (int k = 0; k < n; k++) wdata[k] = $urandom;
            do_burst(start, n, bte, we, sel, stall);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_ram_slave.md
Name: wb_ram_slave

Overview:
- Wishbone B3 slave responder: single-port word RAM with byte-lane writes and registered-feedback burst support.
- Terminates the shared memory bus driven by the instruction/data bus arbiter.
- Responds to classic cycles and to incrementing bursts in linear, wrap-4, wrap-8 and wrap-16 modes.
- Flags out-of-range accesses with err.

Parameters:
- dw, 32, data width; must be 32.
- aw, 32, address width; byte address.
- depth, 1024, memory size in 32-bit words; power of two.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wb_adr_i  in  aw  byte address; word index = wb_adr_i[aw-1:2].
- wb_dat_i  in  dw  write data.
- wb_sel_i  in  4  byte-lane enables; bit n enables bits [8n+7:8n].
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; other values are treated as 000.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_dat_o  out  dw  read data, valid when wb_ack_o=1.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry; constant 0.

Behaviour:
- Reset (async assert, sync deassert by clocking): wb_ack_o=0, wb_err_o=0, wb_rty_o=0, wb_dat_o=0, state=IDLE, cur_adr=0. RAM contents are not reset. Reset mid-burst aborts immediately; no write occurs on the reset edge.
- req = wb_cyc_i & wb_stb_i. "In range" means word index < depth.
- Write commit: a write happens on the rising edge where wb_ack_o=1 & req & wb_we_i. It writes wb_dat_i into mem[cur_adr], masked by wb_sel_i. Read-during-write to the same word returns the old data.
- State IDLE:
  - req & !wb_ack_o & !wb_err_o & out of range -> next cycle wb_err_o=1 for exactly one cycle; no RAM write; stay IDLE.
  - req & !wb_ack_o & in range -> cur_adr <= word index, wb_dat_o <= mem[word index], wb_ack_o=1 next cycle (latency 1).
  - If wb_cti_i==010 on that request -> go to BURST. Otherwise the ack lasts one cycle and the state returns to IDLE; back-to-back classic requests are acked every other cycle.
- State BURST, evaluated each edge:
  - !wb_cyc_i -> IDLE, wb_ack_o=0.
  - wb_ack_o=1 & req & wb_cti_i==111 -> final beat accepted; wb_ack_o=0; IDLE.
  - wb_ack_o=1 & req & cti!=111 -> nxt = next(cur_adr). If nxt is in range: cur_adr<=nxt, wb_dat_o<=mem[nxt], wb_ack_o=1 (one beat per cycle). If out of range: wb_ack_o=0, wb_err_o=1 for one cycle, then IDLE.
  - !wb_stb_i (master wait state) -> wb_ack_o=0, hold cur_adr. When req returns, wb_ack_o=1 on the next cycle with mem[cur_adr] already presented.
  - During BURST, wb_adr_i is ignored; the internal cur_adr is authoritative.
- next(a), on the word index:
  - bte 00: a+1.
  - bte 01: {a[hi:2], a[1:0]+1}.
  - bte 10: {a[hi:3], a[2:0]+1}.
  - bte 11: {a[hi:4], a[3:0]+1}.
  - Low field wraps modulo 4/8/16; upper bits are unchanged. Only a linear burst can leave the range.
- wb_ack_o and wb_err_o are never 1 in the same cycle.
- wb_dat_o holds its last value when wb_ack_o=0.

Test Plan:
- Reset then classic write: adr=0x10, dat=0xDEADBEEF, sel=1111, we=1. Expect ack one cycle after stb, 1-cycle pulse. Then classic read at 0x10 -> dat_o=0xDEADBEEF with ack.
- Byte lanes: write 0x11223344 with sel=1111, then 0xAABBCCDD with sel=0101 at 0x20. Read 0x20 -> 0x11BB33DD.
- Wrap4 read burst: start at word 6, cti=010, bte=01, stb held 4 beats, last beat cti=111. Expect acks on 4 consecutive cycles with words 6,7,4,5; then ack=0 and state IDLE.
- Linear burst at word depth-2 with 3 beats requested. Expect ack for words depth-2 and depth-1, then err_o pulse, no third ack, no write.
- Wait state mid-burst: drop stb for 2 cycles after beat 2 of a linear write burst from word 0. Expect ack=0 during the stall and the burst to resume at word 2. Read back words 0-3 matching the written data.
- Out-of-range classic: adr=depth*4 -> single err_o pulse, ack never asserted. Assert wb_rst_ni=0 mid-burst -> ack/err/dat_o go 0 immediately and the next request starts from IDLE.
